// File: rtl/soc_boot_pkg.sv
// rtl/soc_boot_pkg.sv - shared state encoding, counter width and length clamp for the boot sequencer
package soc_boot_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_HOLD    = 3'd2;
    localparam state_t S_RUN     = 3'd3;
    localparam state_t S_DONE    = 3'd4;
    localparam state_t S_TIMEOUT = 3'd5;

    localparam int CNT_W = 32;

    // Requested image length limited to what instruction memory can hold.
    function automatic int unsigned clamp_len(input int unsigned req, input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/soc_boot_wdog.sv
// rtl/soc_boot_wdog.sv - run-cycle counter with halt/timeout detection
module soc_boot_wdog
    import soc_boot_pkg::*;
#(
    parameter int MAX_CYC = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic             all_halt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             hit_done,
    output logic             hit_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = (MAX_CYC > 0) ? CNT_W'(MAX_CYC - 1) : '0;
    localparam logic             LIMIT_EN = (MAX_CYC != 0);

    // Halt takes priority: timeout only fires when the cores are not all halted.
    assign hit_done    = run & all_halt;
    assign hit_timeout = run & ~all_halt & LIMIT_EN & (cyc_cnt == LIMIT);

    // Count every RUN cycle except the one that ends the run, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (clr) begin
            cyc_cnt <= '0;
        end else if (run && !hit_done && !hit_timeout && (cyc_cnt != '1)) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/soc_boot_ctrl.sv
// rtl/soc_boot_ctrl.sv - boot sequencer: load image, hold cores in reset, run with watchdog
module soc_boot_ctrl
    import soc_boot_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int N_CORE     = 1,
    parameter int HOLD_CYC   = 4,
    parameter int MAX_CYC    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   img_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [N_CORE-1:0] cpu_rst_n,
    input  logic [N_CORE-1:0] core_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cyc_cnt
);

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] widx;
    logic [ADDR_W:0] len_clamped;
    logic [31:0]     hold_cnt;
    logic            start_ok;
    logic            accept;
    logic            run;
    logic            hit_done;
    logic            hit_timeout;

    assign len_clamped = (ADDR_W + 1)'(clamp_len(32'(img_len), IMEM_DEPTH));
    assign start_ok    = (state == S_IDLE) || (state == S_DONE) || (state == S_TIMEOUT);
    assign ld_ready    = (state == S_LOAD);
    assign accept      = ld_valid & ld_ready;
    assign run         = (state == S_RUN);
    assign busy        = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);

    soc_boot_wdog #(
        .MAX_CYC (MAX_CYC)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start & start_ok),
        .run         (run),
        .all_halt    (&core_halt),
        .cyc_cnt     (cyc_cnt),
        .hit_done    (hit_done),
        .hit_timeout (hit_timeout)
    );

    // Sequencer: start handling, image write-out, reset hold and run outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_q      <= '0;
            widx       <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    // Cores go back into reset one cycle after a run ends.
                    cpu_rst_n <= '0;
                    if (start) begin
                        len_q    <= len_clamped;
                        widx     <= '0;
                        hold_cnt <= 32'(HOLD_CYC - 1);
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        state    <= (len_clamped != '0) ? S_LOAD : S_HOLD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= widx[ADDR_W-1:0];
                        imem_wdata <= ld_data;
                        widx       <= widx + 1'b1;
                        if (widx == len_q - 1'b1) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= S_RUN;
                        cpu_rst_n <= '1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (hit_done) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (hit_timeout) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// tb/tb_soc_boot_ctrl.sv - directed self-checking bench for soc_boot_ctrl
module tb_soc_boot_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int N_CORE = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   img_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [N_CORE-1:0] cpu_rst_n;
    logic [N_CORE-1:0] core_halt;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [31:0]       cyc_cnt;

    int checks = 0;
    int errors = 0;

    soc_boot_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .IMEM_DEPTH (1024),
        .N_CORE     (N_CORE),
        .HOLD_CYC   (4),
        .MAX_CYC    (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_len    (img_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .core_halt  (core_halt),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cyc_cnt    (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int writes;
        int addr_err;
        int last_addr;

        rst_n     = 1'b0;
        start     = 1'b0;
        img_len   = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        core_halt = '0;
        tick();
        tick();

        // Reset state
        check("rst_cpu_rst_n", cpu_rst_n, 2'b00);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cyc_cnt", cyc_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Load 4 words with valid held high
        img_len = 11'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t1_ld_ready", ld_ready, 1);
        check("t1_busy", busy, 1);
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'hA0 + 32'(i);
            tick();
            check("t1_we", imem_we, 1);
            check("t1_addr", imem_addr, 64'(i));
            check("t1_data", imem_wdata, 64'(32'hA0 + 32'(i)));
        end
        check("t1_ready_low", ld_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_hold_rst", cpu_rst_n, 2'b00);
            check("t1_hold_we", imem_we, 0);
        end
        tick();
        check("t1_release", cpu_rst_n, 2'b11);
        check("t1_cnt0", cyc_cnt, 0);
        ld_valid = 1'b0;

        // Run to timeout with no halt
        for (int i = 0; i < 19; i++) tick();
        check("t3_cnt19_run", cyc_cnt, 19);
        check("t3_not_yet", timeout, 0);
        tick();
        check("t3_timeout", timeout, 1);
        check("t3_cnt", cyc_cnt, 19);
        check("t3_done", done, 0);
        check("t3_busy", busy, 0);
        tick();
        check("t3_rst_back", cpu_rst_n, 2'b00);
        check("t3_frozen", cyc_cnt, 19);

        // Load 3 words with valid toggling
        img_len = 11'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t2_timeout_clr", timeout, 0);
        check("t2_cnt_clr", cyc_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hB0 + 32'(i);
            tick();
            check("t2_we", imem_we, 1);
            check("t2_addr", imem_addr, 64'(i));
            check("t2_data", imem_wdata, 64'(32'hB0 + 32'(i)));
            ld_valid = 1'b0;
            tick();
            check("t2_bubble_we", imem_we, 0);
        end
        tick();
        tick();
        check("t2_hold_rst", cpu_rst_n, 2'b00);
        tick();
        check("t2_release", cpu_rst_n, 2'b11);

        // Partial halt then full halt
        for (int i = 0; i < 5; i++) tick();
        check("t4_cnt5", cyc_cnt, 5);
        core_halt = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        check("t4_partial_done", done, 0);
        check("t4_cnt9", cyc_cnt, 9);
        core_halt = 2'b11;
        tick();
        check("t4_done", done, 1);
        check("t4_timeout", timeout, 0);
        check("t4_cnt", cyc_cnt, 9);
        core_halt = 2'b00;
        tick();
        check("t4_rst_back", cpu_rst_n, 2'b00);

        // Zero-length image, halt on the last budget cycle
        img_len = 11'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("t5_done_clr", done, 0);
        check("t5_skip_load", ld_ready, 0);
        check("t5_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_we", imem_we, 0);
            check("t5_hold_rst", cpu_rst_n, 2'b00);
        end
        tick();
        check("t5_release", cpu_rst_n, 2'b11);
        for (int i = 0; i < 19; i++) tick();
        check("t4b_cnt19", cyc_cnt, 19);
        core_halt = 2'b11;
        tick();
        check("t4b_done", done, 1);
        check("t4b_timeout", timeout, 0);
        check("t4b_cnt", cyc_cnt, 19);
        core_halt = 2'b00;

        // Oversized image is clamped to memory depth
        img_len = 11'd2000;
        start   = 1'b1;
        tick();
        start     = 1'b0;
        ld_valid  = 1'b1;
        writes    = 0;
        addr_err  = 0;
        last_addr = -1;
        for (int i = 0; i < 1040; i++) begin
            ld_data = 32'(i);
            tick();
            if (imem_we) begin
                if (int'(imem_addr) != writes) addr_err++;
                last_addr = int'(imem_addr);
                writes++;
            end
        end
        check("t5_writes", 64'(writes), 1024);
        check("t5_addr_seq", 64'(addr_err), 0);
        check("t5_last_addr", 64'(last_addr), 1023);
        check("t5_run", cpu_rst_n, 2'b11);
        ld_valid  = 1'b0;
        core_halt = 2'b11;
        tick();
        check("t5_done", done, 1);
        core_halt = 2'b00;
        tick();

        // Asynchronous reset in the middle of a load
        img_len = 11'd8;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data = 32'hC0 + 32'(i);
            tick();
        end
        check("t6_pre_addr", imem_addr, 1);
        ld_data = 32'hC2;
        rst_n   = 1'b0;
        #1;
        check("t6_we", imem_we, 0);
        check("t6_cpu_rst", cpu_rst_n, 2'b00);
        check("t6_ready", ld_ready, 0);
        check("t6_busy", busy, 0);
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("t6_idle_we", imem_we, 0);
        img_len = 11'd2;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'hD0;
        tick();
        check("t6_restart_we", imem_we, 1);
        check("t6_restart_addr", imem_addr, 0);
        check("t6_restart_data", imem_wdata, 32'hD0);
        ld_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
